// File: rtl/branch_resolve_unit.sv
// Resolution side of the fetch branch predictor: carries each fetch prediction through F->D->E,
// detects mispredicts in E, emits a single predictor update per E slot and counts events.
package branch_resolve_pkg;
    typedef enum logic [1:0] {
        CFLOW_NONE   = 2'd0,
        CFLOW_BRANCH = 2'd1,
        CFLOW_JAL    = 2'd2,
        CFLOW_JALR   = 2'd3
    } cflow_mode_t;

    typedef enum logic [1:0] {
        CFHINT_NONE = 2'd0,
        CFHINT_CALL = 2'd1,
        CFHINT_RET  = 2'd2
    } cflow_hint_t;
endpackage

module branch_resolve_unit
    import branch_resolve_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              start,
    input  logic [31:0]       pc_f,
    input  logic              pred_taken_f,
    input  logic [31:0]       pred_target_f,
    input  logic              stall_fd,
    input  logic              flush_fd,
    input  logic              stall_de,
    input  logic              flush_de,
    input  logic [31:0]       pc_e,
    input  cflow_mode_t       cflow_mode_e,
    input  cflow_hint_t       cflow_hint_e,
    input  logic              cflow_taken_e,
    input  logic [31:0]       cflow_target_e,
    output logic              mispredict,
    output logic [31:0]       redirect_pc,
    output logic [31:0]       upd_pc,
    output cflow_mode_t       upd_mode,
    output cflow_hint_t       upd_hint,
    output logic              upd_taken,
    output logic [31:0]       upd_target,
    output logic [CNT_W-1:0]  branch_cnt,
    output logic [CNT_W-1:0]  mispred_cnt
);
    logic        fd_vld_reg, fd_vld_next;
    logic [31:0] fd_pc_reg, fd_pc_next;
    logic        fd_ptk_reg, fd_ptk_next;
    logic [31:0] fd_ptgt_reg, fd_ptgt_next;
    logic        de_vld_reg, de_vld_next;
    logic [31:0] de_pc_reg, de_pc_next;
    logic        de_ptk_reg, de_ptk_next;
    logic [31:0] de_ptgt_reg, de_ptgt_next;

    logic        fire;
    logic        act_taken;
    logic [31:0] act_next;
    logic        wrong;

    // An E slot resolves only on the cycle it actually leaves E.
    assign fire      = de_vld_reg && !stall_de;
    assign act_taken = (cflow_mode_e == CFLOW_BRANCH) ? cflow_taken_e
                     : ((cflow_mode_e == CFLOW_JAL) || (cflow_mode_e == CFLOW_JALR));
    assign act_next  = act_taken ? cflow_target_e : (pc_e + 32'd4);
    assign wrong     = (de_ptk_reg != act_taken)
                     || (de_ptk_reg && act_taken && (de_ptgt_reg != cflow_target_e));
    assign mispredict  = fire && wrong;
    assign redirect_pc = mispredict ? act_next : 32'd0;

    always_comb begin
        fd_vld_next  = fd_vld_reg;
        fd_pc_next   = fd_pc_reg;
        fd_ptk_next  = fd_ptk_reg;
        fd_ptgt_next = fd_ptgt_reg;
        if (flush_fd || mispredict) begin
            fd_vld_next = 1'b0;
        end else if (!stall_fd) begin
            fd_vld_next  = 1'b1;
            fd_pc_next   = pc_f;
            fd_ptk_next  = pred_taken_f;
            fd_ptgt_next = pred_target_f;
        end
    end

    always_comb begin
        de_vld_next  = de_vld_reg;
        de_pc_next   = de_pc_reg;
        de_ptk_next  = de_ptk_reg;
        de_ptgt_next = de_ptgt_reg;
        if (flush_de || mispredict) begin
            de_vld_next = 1'b0;
        end else if (!stall_de) begin
            de_vld_next  = fd_vld_reg;
            de_pc_next   = fd_pc_reg;
            de_ptk_next  = fd_ptk_reg;
            de_ptgt_next = fd_ptgt_reg;
        end
    end

    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            fd_vld_reg  <= 1'b0;
            fd_pc_reg   <= '0;
            fd_ptk_reg  <= 1'b0;
            fd_ptgt_reg <= '0;
            de_vld_reg  <= 1'b0;
            de_pc_reg   <= '0;
            de_ptk_reg  <= 1'b0;
            de_ptgt_reg <= '0;
        end else begin
            fd_vld_reg  <= fd_vld_next;
            fd_pc_reg   <= fd_pc_next;
            fd_ptk_reg  <= fd_ptk_next;
            fd_ptgt_reg <= fd_ptgt_next;
            de_vld_reg  <= de_vld_next;
            de_pc_reg   <= de_pc_next;
            de_ptk_reg  <= de_ptk_next;
            de_ptgt_reg <= de_ptgt_next;
        end
    end

    // Update bundle is gated by fire so a stalled call/ret never pushes or pops the RAS twice.
    always_comb begin
        upd_pc     = 32'd0;
        upd_mode   = CFLOW_NONE;
        upd_hint   = CFHINT_NONE;
        upd_taken  = 1'b0;
        upd_target = 32'd0;
        if (fire) begin
            upd_pc     = pc_e;
            upd_mode   = cflow_mode_e;
            upd_hint   = cflow_hint_e;
            upd_taken  = act_taken;
            upd_target = cflow_target_e;
        end
    end

    logic [1:0]       cnt_inc;
    logic [CNT_W-1:0] cnt_val [2];

    assign cnt_inc[0] = fire && (cflow_mode_e != CFLOW_NONE);
    assign cnt_inc[1] = mispredict;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge clk or posedge start) begin
                if (start) begin
                    cnt_reg <= '0;
                end else if (cnt_inc[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
            assign cnt_val[gi] = cnt_reg;
        end
    endgenerate

    assign branch_cnt  = cnt_val[0];
    assign mispred_cnt = cnt_val[1];

    // A resolving slot whose PC disagrees with E means the hazard unit lost pipeline sync.
    pc_sync_a: assert property (@(posedge clk) disable iff (start) fire |-> (de_pc_reg == pc_e));
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares whenever the unit presents a mispredict or an update.
module tb_branch_resolve_unit;
    import branch_resolve_pkg::*;

    logic        clk;
    logic        start;
    logic [31:0] pc_f;
    logic        pred_taken_f;
    logic [31:0] pred_target_f;
    logic        stall_fd, flush_fd, stall_de, flush_de;
    logic [31:0] pc_e;
    cflow_mode_t cflow_mode_e;
    cflow_hint_t cflow_hint_e;
    logic        cflow_taken_e;
    logic [31:0] cflow_target_e;

    logic        mispredict;
    logic [31:0] redirect_pc, upd_pc, upd_target;
    cflow_mode_t upd_mode;
    cflow_hint_t upd_hint;
    logic        upd_taken;
    logic [31:0] branch_cnt, mispred_cnt;

    logic        mispredict_w;
    logic [31:0] redirect_pc_w, upd_pc_w, upd_target_w;
    cflow_mode_t upd_mode_w;
    cflow_hint_t upd_hint_w;
    logic        upd_taken_w;
    logic [1:0]  branch_cnt_w, mispred_cnt_w;

    branch_resolve_unit #(.CNT_W(32)) dut (
        .clk(clk), .start(start), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .pred_target_f(pred_target_f), .stall_fd(stall_fd), .flush_fd(flush_fd),
        .stall_de(stall_de), .flush_de(flush_de), .pc_e(pc_e), .cflow_mode_e(cflow_mode_e),
        .cflow_hint_e(cflow_hint_e), .cflow_taken_e(cflow_taken_e), .cflow_target_e(cflow_target_e),
        .mispredict(mispredict), .redirect_pc(redirect_pc), .upd_pc(upd_pc), .upd_mode(upd_mode),
        .upd_hint(upd_hint), .upd_taken(upd_taken), .upd_target(upd_target),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    // Narrow-counter copy on identical stimulus exercises counter wrap.
    branch_resolve_unit #(.CNT_W(2)) dut_w (
        .clk(clk), .start(start), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
        .pred_target_f(pred_target_f), .stall_fd(stall_fd), .flush_fd(flush_fd),
        .stall_de(stall_de), .flush_de(flush_de), .pc_e(pc_e), .cflow_mode_e(cflow_mode_e),
        .cflow_hint_e(cflow_hint_e), .cflow_taken_e(cflow_taken_e), .cflow_target_e(cflow_target_e),
        .mispredict(mispredict_w), .redirect_pc(redirect_pc_w), .upd_pc(upd_pc_w), .upd_mode(upd_mode_w),
        .upd_hint(upd_hint_w), .upd_taken(upd_taken_w), .upd_target(upd_target_w),
        .branch_cnt(branch_cnt_w), .mispred_cnt(mispred_cnt_w)
    );

    typedef struct {
        logic        mp;
        logic [31:0] redir;
        logic [31:0] pc;
        cflow_mode_t mode;
        cflow_hint_t hint;
        logic        tk;
        logic [31:0] tgt;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks   = 0;
    int   failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_e();
        pc_e           = 32'd0;
        cflow_mode_e   = CFLOW_NONE;
        cflow_hint_e   = CFHINT_NONE;
        cflow_taken_e  = 1'b0;
        cflow_target_e = 32'd0;
    endtask

    // One instruction through F->D->E with optional E stall; expected values passed in by hand.
    task automatic run_instr(input logic [31:0] pc, input logic ptk, input logic [31:0] ptgt,
                             input cflow_mode_t mode, input cflow_hint_t hint, input logic tk,
                             input logic [31:0] tgt, input int stall, input logic emp,
                             input logic [31:0] eredir, input logic eutk, input int eb, input int em);
        exp_t e;
        pc_f = pc; pred_taken_f = ptk; pred_target_f = ptgt; flush_fd = 1'b0;
        step();
        flush_fd = 1'b1;
        step();
        pc_e = pc; cflow_mode_e = mode; cflow_hint_e = hint;
        cflow_taken_e = tk; cflow_target_e = tgt; stall_de = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_mispredict", 32'(mispredict), 32'd0);
            chk("stall_upd_mode", 32'(upd_mode), 32'(CFLOW_NONE));
            chk("stall_branch_cnt", branch_cnt, 32'(eb - 1));
            step();
        end
        stall_de = 1'b0;
        if (emp) begin
            // Wrong-path fetch that the mispredict must squash.
            flush_fd = 1'b0; pc_f = pc + 32'h1000; pred_taken_f = 1'b0;
        end
        e.mp = emp; e.redir = eredir; e.pc = pc; e.mode = mode;
        e.hint = hint; e.tk = eutk; e.tgt = tgt;
        exp_q.push_back(e);
        step();
        flush_fd = 1'b1;
        clear_e();
        chk("branch_cnt", branch_cnt, 32'(eb));
        chk("mispred_cnt", mispred_cnt, 32'(em));
        chk("branch_cnt_w", 32'(branch_cnt_w), 32'(eb % 4));
        chk("mispred_cnt_w", 32'(mispred_cnt_w), 32'(em % 4));
        if (emp) begin
            chk("fd_vld_after_mispredict", 32'(dut.fd_vld_reg), 32'd0);
            chk("de_vld_after_mispredict", 32'(dut.de_vld_reg), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (!start && (mispredict || upd_mode != CFLOW_NONE)) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_output_pc", upd_pc, 32'hDEAD_BEEF);
            end else begin
                mon_e = exp_q.pop_front();
                chk("mispredict", 32'(mispredict), 32'(mon_e.mp));
                chk("redirect_pc", redirect_pc, mon_e.redir);
                chk("upd_pc", upd_pc, mon_e.pc);
                chk("upd_mode", 32'(upd_mode), 32'(mon_e.mode));
                chk("upd_hint", 32'(upd_hint), 32'(mon_e.hint));
                chk("upd_taken", 32'(upd_taken), 32'(mon_e.tk));
                chk("upd_target", upd_target, mon_e.tgt);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start = 1'b1;
        pc_f = 32'd0; pred_taken_f = 1'b0; pred_target_f = 32'd0;
        stall_fd = 1'b0; flush_fd = 1'b1; stall_de = 1'b0; flush_de = 1'b0;
        clear_e();
        repeat (2) step();
        chk("reset_mispredict", 32'(mispredict), 32'd0);
        chk("reset_redirect_pc", redirect_pc, 32'd0);
        chk("reset_upd_mode", 32'(upd_mode), 32'(CFLOW_NONE));
        chk("reset_branch_cnt", branch_cnt, 32'd0);
        chk("reset_mispred_cnt", mispred_cnt, 32'd0);
        start = 1'b0;
        step();

        //        pc            ptk  ptgt          mode          hint         tk    tgt           st mp   redir         utk  b  m
        run_instr(32'h100,      1'b1, 32'h80,      CFLOW_BRANCH, CFHINT_NONE, 1'b1, 32'h80,      0, 1'b0, 32'h0,       1'b1, 1, 0);
        run_instr(32'h200,      1'b0, 32'h0,       CFLOW_BRANCH, CFHINT_NONE, 1'b1, 32'h40,      0, 1'b1, 32'h40,      1'b1, 2, 1);
        run_instr(32'h400,      1'b1, 32'h300,     CFLOW_JALR,   CFHINT_RET,  1'b0, 32'h340,     0, 1'b1, 32'h340,     1'b1, 3, 2);
        run_instr(32'h600,      1'b1, 32'h500,     CFLOW_JAL,    CFHINT_CALL, 1'b0, 32'h500,     3, 1'b0, 32'h0,       1'b1, 4, 2);
        run_instr(32'hFFFFFFFC, 1'b1, 32'h1234,    CFLOW_NONE,   CFHINT_NONE, 1'b0, 32'h55,      0, 1'b1, 32'h0,       1'b0, 4, 3);
        run_instr(32'h700,      1'b0, 32'h0,       CFLOW_BRANCH, CFHINT_NONE, 1'b0, 32'h900,     0, 1'b0, 32'h0,       1'b0, 5, 3);
        run_instr(32'h800,      1'b1, 32'h840,     CFLOW_BRANCH, CFHINT_NONE, 1'b0, 32'h840,     0, 1'b1, 32'h804,     1'b0, 6, 4);
        run_instr(32'h900,      1'b1, 32'h950,     CFLOW_BRANCH, CFHINT_NONE, 1'b1, 32'h960,     0, 1'b1, 32'h960,     1'b1, 7, 5);
        run_instr(32'hA00,      1'b0, 32'h0,       CFLOW_JAL,    CFHINT_NONE, 1'b0, 32'hA80,     2, 1'b1, 32'hA80,     1'b1, 8, 6);

        // Asynchronous reset while a mispredicting slot sits in E.
        pc_f = 32'hB00; pred_taken_f = 1'b0; pred_target_f = 32'd0; flush_fd = 1'b0;
        step();
        flush_fd = 1'b1;
        step();
        pc_e = 32'hB00; cflow_mode_e = CFLOW_BRANCH; cflow_taken_e = 1'b1; cflow_target_e = 32'hB40;
        #1;
        chk("pre_reset_mispredict", 32'(mispredict), 32'd1);
        start = 1'b1;
        #1;
        chk("async_reset_mispredict", 32'(mispredict), 32'd0);
        chk("async_reset_redirect_pc", redirect_pc, 32'd0);
        chk("async_reset_upd_mode", 32'(upd_mode), 32'(CFLOW_NONE));
        chk("async_reset_branch_cnt", branch_cnt, 32'd0);
        chk("async_reset_mispred_cnt", mispred_cnt, 32'd0);
        chk("async_reset_mispred_cnt_w", 32'(mispred_cnt_w), 32'd0);
        step();
        clear_e();
        start = 1'b0;
        step();
        run_instr(32'hC00, 1'b1, 32'hC80, CFLOW_JAL, CFHINT_NONE, 1'b0, 32'hC80, 0, 1'b0, 32'h0, 1'b1, 1, 0);

        repeat (2) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
